// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-bank writeback arbiter.
package regfile_pkg;

    localparam int INDEX_SIZE = 4;
    localparam int WIDTH      = 32;
    localparam int SEQ_W      = 3;
    localparam int DEPTH      = 2;

    // Half of the sequence space; a younger tag is at most this far ahead.
    localparam logic [SEQ_W-1:0] SEQ_HALF = 3'd4;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

    typedef struct packed {
        logic [INDEX_SIZE-1:0] rd;
        logic [WIDTH-1:0]      wd;
        logic [SEQ_W-1:0]      seq;
    } wb_entry_t;

    // True when tag a was issued before tag b. At most five writes are ever
    // outstanding, so the modulo-8 distance from a to b is 1..4 when a is older.
    function automatic logic seq_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = b - a;
        return (diff != 3'd0) && (diff <= SEQ_HALF);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Two-entry FIFO of tagged writeback entries, with a per-slot view for the busy vector.
module wb_fifo2
    import regfile_pkg::*;
#(
    parameter int DEPTH_P = regfile_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  wb_entry_t       push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output wb_entry_t       head,
    output wb_entry_t [1:0] slots,
    output logic      [1:0] slot_valid
);

    wb_entry_t [1:0] mem;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    assign full  = (count == 2'(DEPTH_P));
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];
    assign slots = mem;

    // Slot rd_ptr holds the head; the other slot is live only when both are used.
    always_comb begin
        slot_valid         = 2'b00;
        slot_valid[rd_ptr] = (count != 2'd0);
        slot_valid[~rd_ptr] = (count == 2'd2);
    end

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a push onto a full-and-popping FIFO reuses the head slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count/slot_valid gate every use,
        // so stale contents are never observed.
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-bank write port between the ALU (src0) and the LSU (src1).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int Index_size = INDEX_SIZE,
    parameter int width      = WIDTH,
    parameter int DEPTH      = regfile_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     s0_valid,
    output logic                     s0_ready,
    input  logic [Index_size-1:0]    s0_rd,
    input  logic [width-1:0]         s0_wd,
    input  logic                     s1_valid,
    output logic                     s1_ready,
    input  logic [Index_size-1:0]    s1_rd,
    input  logic [width-1:0]         s1_wd,
    output logic                     WE,
    output logic [Index_size-1:0]    Rd,
    output logic [width-1:0]         WD,
    output logic [2**Index_size-1:0] busy
);

    logic            full0, full1, empty0, empty1;
    wb_entry_t       head0, head1, entry0, entry1;
    wb_entry_t [1:0] slots0, slots1;
    logic      [1:0] valid0, valid1;
    logic            push0, push1, grant0, grant1, rr_flip;
    logic [SEQ_W-1:0] seq_q;
    src_t            rr_q, rr_d;

    assign s0_ready = !full0 && !rst && !flush;
    assign s1_ready = !full1 && !rst && !flush;

    // Writes to r0 finish the handshake but never enter a buffer.
    assign push0 = s0_valid && s0_ready && (s0_rd != '0);
    assign push1 = s1_valid && s1_ready && (s1_rd != '0);

    // Age tags: src0 takes the current tag, src1 the next one when both enqueue.
    always_comb begin
        entry0 = '{rd: s0_rd, wd: s0_wd, seq: seq_q};
        entry1 = '{rd: s1_rd, wd: s1_wd, seq: push0 ? seq_q + 3'd1 : seq_q};
    end

    wb_fifo2 #(.DEPTH_P(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push0), .push_data(entry0), .pop(grant0 && !flush),
        .full(full0), .empty(empty0), .head(head0),
        .slots(slots0), .slot_valid(valid0)
    );

    wb_fifo2 #(.DEPTH_P(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .flush(flush),
        .push(push1), .push_data(entry1), .pop(grant1 && !flush),
        .full(full1), .empty(empty1), .head(head1),
        .slots(slots1), .slot_valid(valid1)
    );

    // Grant selection: same-rd heads resolve by age, otherwise round-robin.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_flip = 1'b0;
        rr_d    = rr_q;
        if (!empty0 && !empty1) begin
            if (head0.rd == head1.rd) begin
                grant0 = seq_older(head0.seq, head1.seq);
                grant1 = !grant0;
            end else begin
                rr_flip = 1'b1;
                grant0  = (rr_q == SRC0);
                grant1  = (rr_q == SRC1);
            end
        end else begin
            grant0 = !empty0;
            grant1 = !empty1;
        end
        if (rr_flip && !flush) rr_d = (rr_q == SRC0) ? SRC1 : SRC0;
    end

    // Round-robin pointer and global sequence counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q  <= SRC0;
            seq_q <= '0;
        end else begin
            rr_q  <= rr_d;
            seq_q <= seq_q + SEQ_W'(push0) + SEQ_W'(push1);
        end
    end

    // Registered write port; Rd/WD hold when there is nothing to write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE <= 1'b0;
            Rd <= '0;
            WD <= '0;
        end else if (flush) begin
            WE <= 1'b0;
        end else if (grant0 || grant1) begin
            WE <= 1'b1;
            Rd <= grant0 ? head0.rd : head1.rd;
            WD <= grant0 ? head0.wd : head1.wd;
        end else begin
            WE <= 1'b0;
        end
    end

    // Pending-write vector: every buffered entry plus the staged write.
    always_comb begin
        busy = '0;
        for (int i = 0; i < 2; i++) begin
            if (valid0[i]) busy[slots0[i].rd] = 1'b1;
            if (valid1[i]) busy[slots1[i].rd] = 1'b1;
        end
        if (WE) busy[Rd] = 1'b1;
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, a write
// scoreboard with per-source order and same-register age checks, and
// multi-cycle sequences for streaming, flush and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic [3:0]  s0_rd, s1_rd, Rd;
    logic [31:0] s0_wd, s1_wd, WD;
    logic        WE;
    logic [15:0] busy;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_wd(s0_wd),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_wd(s1_wd),
        .WE(WE), .Rd(Rd), .WD(WD), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] wd;
        int unsigned order;
    } exp_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] wd;
    } wr_t;

    typedef struct {
        logic        v0;
        logic [3:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [3:0]  r1;
        logic [31:0] d1;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_we;
        logic [3:0]  e_rd;
        logic [31:0] e_wd;
        logic [15:0] e_busy;
    } vec_t;

    exp_t        exp0[$], exp1[$];
    wr_t         wr_log[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          passes = 0;
    int unsigned order_ctr = 0;
    logic        rdy0, rdy1;
    bit          m0, m1, use0, out_of_age;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // One clock of stimulus, driven at the falling edge; handshakes are
    // recorded into the per-source expectation queues before the rising edge.
    task automatic step(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                        input logic fl, output logic rd0, output logic rd1);
        s0_valid = v0; s0_rd = r0; s0_wd = d0;
        s1_valid = v1; s1_rd = r1; s1_wd = d1;
        flush    = fl;
        #1;
        rd0 = s0_ready;
        rd1 = s1_ready;
        if (v0 && rd0 && r0 != 4'd0) begin
            exp0.push_back('{r0, d0, order_ctr});
            order_ctr++;
        end
        if (v1 && rd1 && r1 != 4'd0) begin
            exp1.push_back('{r1, d1, order_ctr});
            order_ctr++;
        end
        @(posedge clk);
        if (fl) begin
            exp0.delete();
            exp1.delete();
        end
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    // Write scoreboard: each write must be the oldest pending entry of one
    // source, and must not overtake an older pending write to the same register.
    always @(negedge clk) begin
        if (!rst && WE) begin
            wr_log.push_back('{Rd, WD});
            m0 = (exp0.size() > 0) && (exp0[0].rd == Rd) && (exp0[0].wd == WD);
            m1 = (exp1.size() > 0) && (exp1[0].rd == Rd) && (exp1[0].wd == WD);
            checks++;
            if (!m0 && !m1) begin
                $display("FAIL write_match: got rd=%0d wd=0x%08h, expected the head of a source queue", Rd, WD);
            end else begin
                use0 = m0 && (!m1 || exp0[0].order < exp1[0].order);
                if (use0) begin
                    out_of_age = (exp1.size() > 0) && (exp1[0].rd == Rd) && (exp1[0].order < exp0[0].order);
                    void'(exp0.pop_front());
                end else begin
                    out_of_age = (exp0.size() > 0) && (exp0[0].rd == Rd) && (exp0[0].order < exp1[0].order);
                    void'(exp1.pop_front());
                end
                if (out_of_age)
                    $display("FAIL write_age: got rd=%0d wd=0x%08h ahead of an older write, expected age order", Rd, WD);
                else
                    passes++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int i0, i1, stall, viol;

        //           v0 r0  d0            v1 r1  d1      rdy0 rdy1 we rd  wd             busy
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,   1, 1, 0, 0, 32'h0,        16'h0020};
        vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 1, 5, 32'hDEADBEEF, 16'h0020};
        vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 0, 5, 32'hDEADBEEF, 16'h0000};
        vecs[3]  = '{1, 3, 32'h33,       1, 7, 32'h77,  1, 1, 0, 5, 32'hDEADBEEF, 16'h0088};
        vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 1, 3, 32'h33,       16'h0088};
        vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 1, 7, 32'h77,       16'h0080};
        vecs[6]  = '{1, 3, 32'h333,      1, 7, 32'h777, 1, 1, 0, 7, 32'h77,       16'h0088};
        vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 1, 7, 32'h777,      16'h0088};
        vecs[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 1, 3, 32'h333,      16'h0008};
        vecs[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 0, 3, 32'h333,      16'h0000};
        vecs[10] = '{1, 0, 32'hFFFF,     0, 0, 32'h0,   1, 1, 0, 3, 32'h333,      16'h0000};
        vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 1, 0, 3, 32'h333,      16'h0000};

        rst = 1'b1; flush = 1'b0;
        s0_valid = 1'b0; s0_rd = '0; s0_wd = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_wd = '0;
        #1;
        check("reset_we", WE, 0);
        check("reset_rd", Rd, 0);
        check("reset_wd", WD, 0);
        check("reset_busy", busy, 0);
        check("reset_ready0", s0_ready, 0);
        check("reset_ready1", s1_ready, 0);
        #6 rst = 1'b0;
        @(negedge clk);

        // Directed vector table: latency, busy, round-robin, r0 discard.
        for (int v = 0; v < 12; v++) begin
            step(vecs[v].v0, vecs[v].r0, vecs[v].d0, vecs[v].v1, vecs[v].r1, vecs[v].d1, 0, rdy0, rdy1);
            check($sformatf("vec%0d_ready0", v), rdy0, vecs[v].e_rdy0);
            check($sformatf("vec%0d_ready1", v), rdy1, vecs[v].e_rdy1);
            check($sformatf("vec%0d_we", v), WE, vecs[v].e_we);
            check($sformatf("vec%0d_rd", v), Rd, vecs[v].e_rd);
            check($sformatf("vec%0d_wd", v), WD, vecs[v].e_wd);
            check($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
        end

        // Same register from both sources on consecutive edges stays in order.
        wr_log.delete();
        step(0, 0, 0, 1, 9, 32'h11, 0, rdy0, rdy1);
        step(1, 9, 32'h22, 0, 0, 0, 0, rdy0, rdy1);
        idle(3);
        check("same_rd_count", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check("same_rd_first", wr_log[0].wd, 32'h11);
            check("same_rd_second", wr_log[1].wd, 32'h22);
        end

        // Pointer untouched by the single grants above: src0 still wins.
        wr_log.delete();
        step(1, 4, 32'h44, 1, 6, 32'h66, 0, rdy0, rdy1);
        idle(3);
        check("rr_kept_count", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check("rr_kept_first", wr_log[0].rd, 4);
            check("rr_kept_second", wr_log[1].rd, 6);
        end

        // Streaming: six requests per source offered back to back.
        wr_log.delete();
        i0 = 0; i1 = 0; stall = 0;
        for (int c = 0; c < 40 && (i0 < 6 || i1 < 6); c++) begin
            step(i0 < 6, 4'(1 + i0), 32'h1000 + i0, i1 < 6, 4'(8 + i1), 32'h2000 + i1, 0, rdy0, rdy1);
            if (i0 < 6 && !rdy0) stall++;
            if (i1 < 6 && !rdy1) stall++;
            if (i0 < 6 && rdy0) i0++;
            if (i1 < 6 && rdy1) i1++;
        end
        check("stream_src0_accepted", i0, 6);
        check("stream_src1_accepted", i1, 6);
        check("stream_backpressure", stall > 0, 1);
        idle(5);
        check("stream_writes", wr_log.size(), 12);
        viol = 0;
        for (int k = 1; k < wr_log.size(); k++)
            if ((wr_log[k].rd >= 4'd8) == (wr_log[k-1].rd >= 4'd8)) viol++;
        check("stream_alternate", viol, 0);
        check("stream_drained", exp0.size() + exp1.size(), 0);

        // Flush with entries queued and a write staged.
        step(1, 10, 32'hA0, 1, 11, 32'hB0, 0, rdy0, rdy1);
        step(1, 12, 32'hA1, 1, 13, 32'hB1, 0, rdy0, rdy1);
        step(1, 14, 32'hA2, 1, 15, 32'hB2, 1, rdy0, rdy1);
        check("flush_ready0_low", rdy0, 0);
        check("flush_ready1_low", rdy1, 0);
        check("flush_we", WE, 0);
        check("flush_busy", busy, 0);
        #1;
        check("flush_ready0_after", s0_ready, 1);
        check("flush_ready1_after", s1_ready, 1);
        @(negedge clk);
        idle(4);

        // Asynchronous reset in the middle of traffic.
        step(1, 2, 32'hC0, 1, 5, 32'hD0, 0, rdy0, rdy1);
        step(1, 3, 32'hC1, 1, 6, 32'hD1, 0, rdy0, rdy1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we", WE, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready0", s0_ready, 0);
        check("rst_mid_ready1", s1_ready, 0);
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_rel_we", WE, 0);
        check("rst_rel_busy", busy, 0);
        check("rst_rel_ready0", s0_ready, 1);
        check("rst_rel_ready1", s1_ready, 1);
        @(negedge clk);
        idle(4);

        // Post-reset traffic: pointer back at src0.
        wr_log.delete();
        step(1, 12, 32'hE0, 1, 13, 32'hF0, 0, rdy0, rdy1);
        idle(3);
        check("post_rst_count", wr_log.size(), 2);
        if (wr_log.size() >= 2) check("post_rst_first", wr_log[0].rd, 12);
        check("final_drained", exp0.size() + exp1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the register bank (WE, Rd, WD) between two writeback sources: src0 (ALU) and src1 (load/store unit).
- Each source has a 2-entry buffer with a valid/ready handshake.
- Arbitration is round-robin, but writes to the same register are kept in age order.
- Drives the register bank write port from registered outputs and exports a pending-write busy vector for the hazard/stall unit.

Parameters:
Index_size, 4, register index width (2**Index_size registers)
width, 32, data width
DEPTH, 2, entries per source buffer (fixed at 2 for this revision)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of all queued and staged writes
s0_valid  in  1  src0 write request
s0_ready  out  1  src0 buffer can accept
s0_rd  in  Index_size  src0 destination register
s0_wd  in  width  src0 write data
s1_valid  in  1  src1 write request
s1_ready  out  1  src1 buffer can accept
s1_rd  in  Index_size  src1 destination register
s1_wd  in  width  src1 write data
WE  out  1  register bank write enable
Rd  out  Index_size  register bank write index
WD  out  width  register bank write data
busy  out  2**Index_size  bit r = write to r queued or staged

Behaviour:
- Clock and reset:
  - Single clock domain (clk). rst is asynchronous and active-high.
  - While rst is high: buffers empty; WE=0, Rd=0, WD=0; busy=0; s0_ready=s1_ready=0; round-robin pointer = src0; sequence counter = 0.
- Handshake:
  - sN_ready = buffer N not full and rst low. It does not depend on sN_valid.
  - A transfer occurs on the rising edge where sN_valid & sN_ready.
  - A pop in the same cycle does not raise ready in that cycle. There is no pass-through.
- Register 0:
  - A request with rd=0 completes the handshake normally but is discarded.
  - It creates no buffer entry, no WE and no busy bit, and does not advance the sequence counter.
- Age tagging:
  - Each enqueued entry stores {rd, wd, seq}, where seq is a 3-bit global counter.
  - The counter advances by 1 per enqueued entry.
  - If both sources enqueue on the same edge: src0 takes seq, src1 takes seq+1, and the counter advances by 2.
  - Older-than comparison is modulo-8 difference, which is valid because at most 5 writes are outstanding.
- Arbitration (each cycle, on the buffer heads):
  - One head valid: grant it.
  - Both heads valid, same rd: grant the older seq.
  - Both heads valid, different rd: grant the source named by the round-robin pointer. After a round-robin grant the pointer moves to the other source.
  - Age-based grants do not move the pointer.
  - The granted head is popped on the next edge.
- Output stage:
  - On the edge that pops a head: WE<=1, Rd<=head.rd, WD<=head.wd.
  - With no grant: WE<=0, and Rd/WD hold their values.
- Latency:
  - Request accepted at edge k; WE is high in the cycle after edge k+1; the register bank writes at edge k+2.
  - Throughput is 1 write per cycle total.
- busy:
  - Combinational OR of decoded rd over all valid buffer entries plus the output stage when WE=1.
  - busy[0] is always 0.
- flush:
  - On the edge where flush=1: both buffers are emptied, WE<=0, and requests presented that cycle are not accepted. sN_ready is forced to 0 during flush.
  - The round-robin pointer and sequence counter keep their values.
- Reset mid-operation clears everything immediately, including a WE currently asserted. A write in flight is lost; that is by design.
- Simultaneous enqueue and pop on the same buffer: legal when the buffer is full-then-popping; the result is depth-preserving.

Decomposition:
- regfile_pkg:
  - SEQ_W=3.
  - DEPTH=2.
  - typedef wb_entry_t, a struct {rd, wd, seq} parameterised by Index_size/width. Use package localparams matching the defaults.
  - function seq_older(a,b).
- Sub-module wb_fifo2: 2-entry FIFO of wb_entry_t with push/pop/full/empty/head and an entries-valid view for busy. Instantiated once per source.

Test Plan:
- Reset release, s0: rd=5, wd=0xDEADBEEF at edge 1 -> WE=1, Rd=5, WD=0xDEADBEEF in the cycle after edge 2; busy[5]=1 from edge 1 until WE drops; other bits 0.
- Same edge: s0 rd=3 and s1 rd=7 -> Rd=3 first (pointer=src0 after reset), Rd=7 next cycle; a repeat pair then grants src1 (rd=7) first.
- s1 rd=9 wd=0x11 at edge 1, s0 rd=9 wd=0x22 at edge 2 -> writes in order 0x11 then 0x22; the pointer is unchanged.
- Both sources valid for 6 consecutive cycles with distinct rds -> grants alternate; s0_ready/s1_ready drop when a buffer holds 2; no request is lost or duplicated; 6+6 writes appear in per-source order.
- s0 rd=0 wd=0xFFFF -> s0_ready=1, transfer completes, WE stays 0, busy stays 0.
- Both buffers full, then flush=1 for one cycle (separately: rst=1 asynchronously mid-stream) -> next cycle WE=0, busy=0, both readies=1; no write of the flushed entries ever appears.
